// File: rtl/captura_contador.sv
// captura_contador: synchronises a 3-bit ripple-counter output, filters ripple
// transients, classifies each accepted value and extends it with a wrap count.
//
// Ports:
//   Clock      : system clock, all state updates on the rising edge
//   Reset      : synchronous active-high reset (highest priority)
//   Clear      : synchronous active-high functional clear
//   S_in       : raw ripple-counter output, asynchronous to Clock
//   Valor      : last accepted stable count value
//   Total      : extended count {Voltas, Valor}
//   Incremento : one-cycle pulse, accepted value is previous Valor+1 mod 8
//   Volta      : one-cycle pulse, accepted transition 7->0
//   Erro       : one-cycle pulse, accepted value is not previous Valor+1 mod 8
//   ErroFlag   : sticky error flag, cleared only by Reset or Clear
module captura_contador #(
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_WIDTH    = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic [2:0]            S_in,
    output logic [2:0]            Valor,
    output logic [WRAP_WIDTH+2:0] Total,
    output logic                  Incremento,
    output logic                  Volta,
    output logic                  Erro,
    output logic                  ErroFlag
);

    localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

    logic [2:0]            s1_q, s1_d;
    logic [2:0]            s2_q, s2_d;
    logic [2:0]            cand_q, cand_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            valor_q, valor_d;
    logic [WRAP_WIDTH-1:0] voltas_q, voltas_d;
    logic                  erro_flag_q, erro_flag_d;
    logic                  inc_q, inc_d;
    logic                  volta_q, volta_d;
    logic                  erro_q, erro_d;
    logic                  acc;

    // A value is taken only once it has stayed in s2 for the full window
    // and differs from what is already held, so each stable value is
    // accepted exactly once.
    assign acc = (cnt_q == STAB) && (s2_q == cand_q) && (cand_q != valor_q);

    always_comb begin
        s1_d        = S_in;
        s2_d        = s1_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        valor_d     = valor_q;
        voltas_d    = voltas_q;
        erro_flag_d = erro_flag_q;
        inc_d       = 1'b0;
        volta_d     = 1'b0;
        erro_d      = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = 4'd1;
        end else if (cnt_q < STAB) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (acc) begin
            valor_d = cand_q;
            if (cand_q == valor_q + 3'd1) begin
                inc_d = 1'b1;
                if (valor_q == 3'd7) begin
                    volta_d  = 1'b1;
                    voltas_d = voltas_q + WRAP_WIDTH'(1);
                end
            end else begin
                erro_d      = 1'b1;
                erro_flag_d = 1'b1;
            end
        end
        if (Clear) begin
            s1_d        = '0;
            s2_d        = '0;
            cand_d      = '0;
            cnt_d       = '0;
            valor_d     = '0;
            voltas_d    = '0;
            erro_flag_d = 1'b0;
            inc_d       = 1'b0;
            volta_d     = 1'b0;
            erro_d      = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            valor_q     <= '0;
            voltas_q    <= '0;
            erro_flag_q <= 1'b0;
            inc_q       <= 1'b0;
            volta_q     <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            valor_q     <= valor_d;
            voltas_q    <= voltas_d;
            erro_flag_q <= erro_flag_d;
            inc_q       <= inc_d;
            volta_q     <= volta_d;
            erro_q      <= erro_d;
        end
    end

    assign Valor      = valor_q;
    assign Total      = {voltas_q, valor_q};
    assign Incremento = inc_q;
    assign Volta      = volta_q;
    assign Erro       = erro_q;
    assign ErroFlag   = erro_flag_q;

endmodule

// File: tb/tb_captura_contador.sv
// tb_captura_contador: scoreboard bench for captura_contador with directed vectors.
module tb_captura_contador;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Clear = 1'b0;
    logic [2:0] S_in  = 3'd0;
    logic [2:0] Valor;
    logic [7:0] Total;
    logic       Incremento, Volta, Erro, ErroFlag;

    captura_contador #(.STABLE_CYCLES(2), .WRAP_WIDTH(5)) dut (
        .Clock(Clock), .Reset(Reset), .Clear(Clear), .S_in(S_in),
        .Valor(Valor), .Total(Total), .Incremento(Incremento),
        .Volta(Volta), .Erro(Erro), .ErroFlag(ErroFlag)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0] v;
        logic       inc;
        logic       volta;
        logic       erro;
        logic [7:0] tot;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int n_inc = 0;
    int n_volta = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
        total++;
        if (a !== r) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, r);
        end
    endtask

    task automatic push(input logic [2:0] v, input logic inc, input logic volta,
                        input logic erro, input logic [7:0] tot);
        exp_t e;
        e.v = v; e.inc = inc; e.volta = volta; e.erro = erro; e.tot = tot;
        q.push_back(e);
    endtask

    task automatic step(input logic [2:0] v, input int hold);
        S_in = v;
        repeat (hold) @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int n0, v0;
        fork
            forever begin
                @(negedge Clock);
                if (Incremento || Volta || Erro) begin
                    if (Incremento) n_inc++;
                    if (Volta) n_volta++;
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", {Valor, Incremento, Volta, Erro, Total}, 32'hFFFF);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("event", {Valor, Incremento, Volta, Erro, Total},
                            {e.v, e.inc, e.volta, e.erro, e.tot});
                    end
                end
            end
        join_none

        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        step(0, 20);
        chk("idle_valor", Valor, 0);
        chk("idle_total", Total, 0);
        chk("idle_flag", ErroFlag, 0);

        push(1, 1, 0, 0, 1); step(1, 10);
        push(2, 1, 0, 0, 2); step(2, 10);
        push(3, 1, 0, 0, 3);
        S_in = 3'd3;
        repeat (4) @(posedge Clock);
        #1 chk("latency_edge4", Valor, 2);
        @(posedge Clock);
        #1 chk("latency_edge5", {Valor, Incremento, Erro}, {3'd3, 1'b1, 1'b0});
        @(posedge Clock);
        #1 chk("inc_one_cycle", Incremento, 0);
        repeat (4) @(negedge Clock);

        step(2, 1);
        step(0, 1);
        push(4, 1, 0, 0, 4); step(4, 10);
        chk("ripple_valor", Valor, 4);
        chk("ripple_flag", ErroFlag, 0);

        Clear = 1'b1; S_in = 3'd0;
        @(negedge Clock);
        Clear = 1'b0;
        step(0, 5);
        n0 = n_inc; v0 = n_volta;
        for (int v = 1; v < 8; v++) begin
            push(3'(v), 1, 0, 0, 8'(v));
            step(3'(v), 10);
        end
        push(0, 1, 1, 0, 8); step(0, 10);
        chk("count_incs", n_inc - n0, 8);
        chk("count_voltas", n_volta - v0, 1);
        chk("count_total", Total, 8);

        for (int v = 1; v < 6; v++) begin
            push(3'(v), 1, 0, 0, 8'(8 + v));
            step(3'(v), 10);
        end
        push(1, 0, 0, 1, 9); step(1, 10);
        chk("err_valor", Valor, 1);
        chk("err_flag", ErroFlag, 1);
        step(1, 10);
        chk("err_flag_sticky", ErroFlag, 1);
        Clear = 1'b1; S_in = 3'd0;
        @(negedge Clock);
        Clear = 1'b0;
        chk("clear_flag", ErroFlag, 0);
        chk("clear_total", Total, 0);
        step(0, 5);

        for (int w = 0; w < 32; w++) begin
            for (int v = 1; v < 8; v++) begin
                push(3'(v), 1, 0, 0, {5'(w), 3'(v)});
                step(3'(v), 6);
            end
            push(0, 1, 1, 0, {5'(w + 1), 3'd0});
            step(0, 6);
            if (w == 30) chk("wrap31_total", Total, 248);
        end
        chk("wrap_rollover", Total, 0);

        S_in = 3'd3;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1; Clear = 1'b1; S_in = 3'd0;
        @(negedge Clock);
        chk("rc_outputs", {Valor, Total, Incremento, Volta, Erro, ErroFlag}, 0);
        Reset = 1'b0; Clear = 1'b0;
        step(0, 20);
        chk("rc_no_pending", Valor, 0);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/captura_contador.md
Name: captura_contador

Overview:
Downstream consumer of the 3-bit ripple (asynchronous) counter. It samples the counter's unsynchronised output into the Clock domain with a 2-flop synchroniser. A stability filter rejects ripple transients. Each accepted new value is classified as a legal increment, a wrap, or an error, and the block extends the count with a wrap counter so later stages see a clean, synchronous, wide count.

Parameters:
STABLE_CYCLES, 2, consecutive identical synchronised samples required before a value is accepted (legal range 1..15).
WRAP_WIDTH, 5, width of the wrap counter Voltas.

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Clear  input  1  synchronous functional clear, active-high
S_in  input  3  raw ripple-counter output S, asynchronous to Clock
Valor  output  3  last accepted (stable) count value
Total  output  WRAP_WIDTH+3  extended count {Voltas, Valor}
Incremento  output  1  one-cycle pulse: accepted value = previous Valor+1 mod 8
Volta  output  1  one-cycle pulse: accepted transition 7->0
Erro  output  1  one-cycle pulse: accepted value is not previous Valor+1 mod 8
ErroFlag  output  1  sticky error flag, set by Erro, cleared only by Reset/Clear

Behaviour:
- Reset (sync, highest priority): s1, s2, cand, cnt, Valor, Voltas, ErroFlag = 0; Incremento, Volta, Erro = 0.
- Clear: same effect as Reset on every register; Reset has priority over Clear; Clear has priority over acceptance.
- Synchroniser: s1 <= S_in; s2 <= s1. No logic between s1 and s2.
- Filter state: cand[2:0], cnt[3:0].
  - If s2 != cand: cand <= s2, cnt <= 1.
  - Else, if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - Otherwise cnt holds; it saturates at STABLE_CYCLES.
- Acceptance: condition is cnt == STABLE_CYCLES && s2 == cand && cand != Valor (all registered values).
  - Valor <= cand on that edge.
  - Exactly one acceptance per distinct stable value.
- Latency: counting edge 1 as the first rising edge that samples the new S_in into s1, Valor updates on edge 3+STABLE_CYCLES. Default latency is 5 edges.
- Transient rejection: a value that is present in s2 for fewer than STABLE_CYCLES consecutive cycles is never accepted. Ripple intermediates such as 3->2->0->4 (for a 3->4 step) are discarded when they last less than that window.
- Classification, registered on the acceptance edge:
  - cand == Valor+1 mod 8: Incremento = 1 for one cycle.
  - Additionally, if Valor == 7 and cand == 0: Volta = 1 for one cycle, and Voltas <= Voltas+1 (wraps modulo 2^WRAP_WIDTH, no saturation).
  - Any other value: Erro = 1 for one cycle, ErroFlag <= 1. Valor still updates to cand. Voltas is unchanged.
  - Incremento and Erro are mutually exclusive. Volta implies Incremento.
- Pulse outputs are 0 in every cycle without an acceptance.
- Total = {Voltas, Valor}, purely combinational concatenation of registers.
- Ripple-counter reset to 0 while Valor != 7 and Valor != 0 is reported as Erro. Upstream must assert Clear alongside the ripple counter's Reset to avoid this.
- After Reset/Clear deassert, the block accepts nothing until s2 differs from 0 and is stable. A stable S_in = 0 produces no pulses.

Test Plan:
- Reset then S_in held at 0 for 20 cycles -> Valor = 0, Total = 0, no pulses, ErroFlag = 0.
- From Valor = 2, S_in steps cleanly to 3 -> Valor = 3 on edge 5 after the change, Incremento high exactly 1 cycle, Erro = 0.
- Drive 3 -> 2 (1 cycle) -> 0 (1 cycle) -> 4, with default STABLE_CYCLES = 2 -> only 4 accepted, single Incremento, no Erro.
- Count 0..7 then 0 with each value held 10 cycles -> 8 Incremento pulses, Volta exactly once at 7->0, Total = 8 (Voltas = 1, Valor = 0).
- From Valor = 5, S_in jumps to 1 -> Valor = 1, Erro pulse, ErroFlag stays 1. Clear for 1 cycle -> ErroFlag = 0, Total = 0.
- Complete 32 wraps with WRAP_WIDTH = 5 -> Voltas rolls 31->0. Assert Reset and Clear together mid-filter (cnt = 1) -> all outputs 0 next edge, no pending acceptance.
